u109_cycle_termination: RTL

- Motorola-side cycle terminator for CPU accesses to PCI space; sits between the 040 bus and the U109 CDC FIFO write/read ports.
- Qualifies each CPU transfer, paces it against FIFO readiness and drives the CPU bus termination outputs TACKn, TEAn and TBIn.
- Issues the single-cycle FIFO strobes fifo_wr_valid and fifo_rd_valid.
- Runs entirely in the CLKB (40 MHz) domain; all PCI-side status arrives already synchronized.

---
 rtl/u109_cycle_termination.sv | 108 ++++++++++
 1 files changed

// File: rtl/u109_cycle_termination.sv
// rtl/u109_cycle_termination.sv - Motorola-side terminator for CPU cycles to PCI space via the U109 FIFO
// Optional macro U109_BURST_EN: run SIZ=2'b11 line transfers as four paced beats instead of burst-inhibiting them.
module u109_cycle_termination #(
    parameter int TO_WIDTH = 8,
    parameter int TO_LIMIT = 200
) (
    input  logic       CLKB,
    input  logic       RESET,
    input  logic       TSn,
    input  logic       PCICYCLEn,
    input  logic       RnW,
    input  logic [1:0] SIZ,
    input  logic       PCI_ERR,
    input  logic       fifo_wr_ready,
    input  logic       fifo_rd_ready,
    output logic       TACKn,
    output logic       TEAn,
    output logic       TBIn,
    output logic       fifo_wr_valid,
    output logic       fifo_rd_valid,
    output logic       D_OE,
    output logic       BUSY
);

`ifdef U109_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam logic [TO_WIDTH-1:0] WD_MAX = TO_WIDTH'(TO_LIMIT);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;

    state_t              state;
    logic                rnw_q;
    logic [1:0]          siz_q;
    logic [TO_WIDTH-1:0] wd;
    logic [1:0]          beat;
    logic                line;
    logic                last_beat;
    logic                ready;
    logic                wd_hit;

    assign line      = (siz_q == 2'b11);
    assign last_beat = (beat == ((BURST && line) ? 2'd3 : 2'd0));
    assign ready     = rnw_q ? fifo_rd_ready : fifo_wr_ready;
    assign wd_hit    = (wd == WD_MAX);

    // Outputs are registered from the state held during the previous clock,
    // so TACKn/TEAn/strobes appear exactly one clock after ACK/ERR is entered.
    always_ff @(posedge CLKB or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            rnw_q         <= 1'b0;
            siz_q         <= 2'b00;
            wd            <= '0;
            beat          <= 2'd0;
            TACKn         <= 1'b1;
            TEAn          <= 1'b1;
            TBIn          <= 1'b1;
            fifo_wr_valid <= 1'b0;
            fifo_rd_valid <= 1'b0;
            D_OE          <= 1'b0;
            BUSY          <= 1'b0;
        end else begin
            TACKn         <= !(state == ACK);
            TEAn          <= !(state == ERR);
            TBIn          <= !((state == ACK || state == ERR) && line && !BURST);
            fifo_rd_valid <= (state == ACK) && rnw_q;
            fifo_wr_valid <= (state == ACK) && !rnw_q;
            D_OE          <= (state == WAIT || state == ACK) && rnw_q;
            BUSY          <= (state != IDLE);

            case (state)
                IDLE: begin
                    if (!TSn && !PCICYCLEn) begin
                        rnw_q <= RnW;
                        siz_q <= SIZ;
                        wd    <= '0;
                        beat  <= 2'd0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!wd_hit) wd <= wd + TO_WIDTH'(1);
                    if (PCI_ERR || wd_hit) state <= ERR;
                    else if (ready)        state <= ACK;
                end
                ACK: begin
                    beat <= beat + 2'd1;
                    if (last_beat) begin
                        state <= IDLE;
                    end else begin
                        wd    <= '0;
                        state <= WAIT;
                    end
                end
                ERR: begin
                    beat  <= 2'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
